// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit seven-segment scan controller with dead-time and frame-aligned updates
// Display contents are double-buffered; pending data moves to the active set only at the frame wrap.
module seg_scan_ctrl #(
  parameter int PERIOD = 100_000,
  parameter int DEAD   = 1_000
) (
  input  logic        CLK100,
  input  logic        RST,
  input  logic        upd_valid,
  input  logic [31:0] upd_digits,
  input  logic [7:0]  upd_dp,
  input  logic [7:0]  upd_blank,
  output logic        upd_pending,
  output logic        frame_tick,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  logic [31:0]   act_digits_q, act_digits_d;
  logic [7:0]    act_dp_q, act_dp_d;
  logic [7:0]    act_blank_q, act_blank_d;

  logic [31:0]   pend_digits_q, pend_digits_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic [7:0]    pend_blank_q, pend_blank_d;
  logic          pending_q, pending_d;

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic          slot_wrap;
  logic          commit;
  logic          drive;
  logic [3:0]    nibble;
  logic [6:0]    hex_seg;

  // Slot and digit counters; the commit point is the last cycle of digit 7.
  always_comb begin
    slot_wrap = (cnt_q == CNT_MAX);
    commit    = slot_wrap && (idx_q == 3'd7);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = slot_wrap ? idx_q + 3'd1 : idx_q;
  end

  // Update path: newest strobe wins; a strobe on the commit cycle bypasses the pending set.
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pending_d     = pending_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;

    if (commit) begin
      pending_d = 1'b0;
      if (upd_valid) begin
        act_digits_d = upd_digits;
        act_dp_d     = upd_dp;
        act_blank_d  = upd_blank;
      end else if (pending_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_blank_d  = pend_blank_q;
      end
    end else if (upd_valid) begin
      pend_digits_d = upd_digits;
      pend_dp_d     = upd_dp;
      pend_blank_d  = upd_blank;
      pending_d     = 1'b1;
    end
  end

  always_comb begin
    nibble = act_digits_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  end

  // A blanked digit keeps the dead-time pattern for its whole slot.
  always_comb begin
    drive  = (cnt_q >= DEAD_END) && !act_blank_q[idx_q];
    an_d   = drive ? ~(8'h01 << idx_q) : 8'hFF;
    seg_d  = drive ? hex_seg : 7'h7F;
    dp_d   = drive ? ~act_dp_q[idx_q] : 1'b1;
    tick_d = commit;
  end

  always_ff @(posedge CLK100) begin
    if (RST) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      act_digits_q  <= 32'h0;
      act_dp_q      <= 8'h00;
      act_blank_q   <= 8'hFF;
      pend_digits_q <= 32'h0;
      pend_dp_q     <= 8'h00;
      pend_blank_q  <= 8'h00;
      pending_q     <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      tick_q        <= tick_d;
    end
  end

  assign upd_pending = pending_q;
  assign frame_tick  = tick_q;
  assign AN          = an_q;
  assign SEG         = seg_q;
  assign DP          = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl (PERIOD=8, DEAD=2)
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_digits;
  logic [7:0]  upd_dp;
  logic [7:0]  upd_blank;
  logic        upd_pending;
  logic        frame_tick;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.PERIOD(8), .DEAD(2)) dut (
    .CLK100      (clk),
    .RST         (rst),
    .upd_valid   (upd_valid),
    .upd_digits  (upd_digits),
    .upd_dp      (upd_dp),
    .upd_blank   (upd_blank),
    .upd_pending (upd_pending),
    .frame_tick  (frame_tick),
    .AN          (an),
    .SEG         (seg),
    .DP          (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [31:0]     digits;
    logic [7:0]      dpm;
    logic [7:0]      blank;
    logic [7:0][6:0] seg;
  } rec_t;

  rec_t vec [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    upd_digits = d;
    upd_dp     = p;
    upd_blank  = b;
    upd_valid  = 1'b1;
    @(negedge clk);
    upd_valid  = 1'b0;
    check("pending_after_strobe", {31'b0, upd_pending}, 32'd1);
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_tick_seen"}, {31'b0, frame_tick}, 32'd1);
    check({name, "_pending_cleared"}, {31'b0, upd_pending}, 32'd0);
  endtask

  // Checks one full frame; called right after a commit-cycle sample (or reset release).
  task automatic check_frame(input rec_t r);
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       drv;
    for (int j = 0; j < 64; j++) begin
      int s = j / 8;
      int c = j % 8;
      @(negedge clk);
      drv     = (c >= 2) && !r.blank[s];
      exp_an  = drv ? ~(8'h01 << s) : 8'hFF;
      exp_seg = drv ? r.seg[s] : 7'h7F;
      exp_dp  = drv ? ~r.dpm[s] : 1'b1;
      check($sformatf("%s_s%0d_c%0d {AN,SEG,DP,tick,pend}", r.name, s, c),
            {14'b0, an, seg, dp, frame_tick, upd_pending},
            {14'b0, exp_an, exp_seg, exp_dp, (j == 63), 1'b0});
    end
  endtask

  initial begin
    vec[0] = '{"dark",  32'h0,        8'h00, 8'hFF,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vec[1] = '{"asc",   32'h76543210, 8'h01, 8'h00,
               {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};
    vec[2] = '{"hi",    32'hFEDCBA98, 8'h80, 8'h00,
               {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}};
    vec[3] = '{"blank", 32'h76543210, 8'h00, 8'h0A,
               {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};
    vec[4] = '{"allF",  32'hFFFFFFFF, 8'h00, 8'h00,
               {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};
    vec[5] = '{"allA",  32'hAAAAAAAA, 8'h00, 8'h00,
               {7'h08, 7'h08, 7'h08, 7'h08, 7'h08, 7'h08, 7'h08, 7'h08}};

    rst        = 1'b1;
    upd_valid  = 1'b0;
    upd_digits = 32'h0;
    upd_dp     = 8'h00;
    upd_blank  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {14'b0, an, seg, dp, frame_tick, upd_pending},
          {14'b0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});

    rst = 1'b0;
    check_frame(vec[0]);

    for (int i = 1; i <= 3; i++) begin
      strobe(vec[i].digits, vec[i].dpm, vec[i].blank);
      wait_tick(vec[i].name);
      check_frame(vec[i]);
    end

    // Two strobes in one frame: newest wins.
    strobe(32'h11111111, 8'h00, 8'h00);
    repeat (9) @(negedge clk);
    check("pending_between_strobes", {31'b0, upd_pending}, 32'd1);
    strobe(vec[4].digits, vec[4].dpm, vec[4].blank);
    wait_tick("newest");
    check_frame(vec[4]);

    // Strobe exactly on the commit cycle.
    repeat (63) @(negedge clk);
    check("pre_commit_no_tick", {31'b0, frame_tick}, 32'd0);
    upd_digits = vec[5].digits;
    upd_dp     = vec[5].dpm;
    upd_blank  = vec[5].blank;
    upd_valid  = 1'b1;
    @(negedge clk);
    upd_valid  = 1'b0;
    check("simul_tick", {31'b0, frame_tick}, 32'd1);
    check("simul_no_pending", {31'b0, upd_pending}, 32'd0);
    check_frame(vec[5]);

    // Reset in the middle of slot 5 with an update pending.
    strobe(vec[1].digits, vec[1].dpm, vec[1].blank);
    repeat (44) @(negedge clk);
    check("mid_slot5_an", {24'b0, an}, {24'b0, 8'hDF});
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {14'b0, an, seg, dp, frame_tick, upd_pending},
          {14'b0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    check_frame(vec[0]);
    check_frame(vec[0]);

    strobe(vec[1].digits, vec[1].dpm, vec[1].blank);
    wait_tick("post_reset");
    check_frame(vec[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
